closest_hit_collector: RTL and testbench
========================================

# closest_hit_collector

Downstream consumer of the pipelined triangle-intersection stage. It counts the per-triangle result stream for one ray batch and tracks the nearest hit: minimum `t` plus its triangle index. When the batch is complete it pushes one hit record into a small output FIFO, which the shading/writeback stage drains through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4: output record FIFO depth, power of two, at least 2.
- IDX_W, 32: width of triangle count and index.
---
- i_clk  in  1  clock
- i_rstn  in  1  reset, synchronous, active-low
- i_start  in  1  batch start; `i_tri_cnt` is sampled here; honoured only when `o_busy`=0
- i_tri_cnt  in  IDX_W  triangles in the batch, unsigned
- o_busy  out  1  high from accepted start until the record is pushed
- i_valid  in  1  intersection result valid (one triangle per cycle, no backpressure)
- i_result  in  1  triangle hit
- i_t  in  32  signed Q16.16 hit distance
- o_valid  out  1  FIFO head valid
- i_ready  in  1  consumer accepts head
- o_hit  out  1  record: any hit in batch
- o_t  out  32  record: minimum t, or 0x7fffffff if no hit
- o_tri_idx  out  IDX_W  record: index of nearest triangle, or 0 if no hit
- o_err  out  1  sticky: `i_valid` arrived while not in ACCUM

## Operation
- States:
  - IDLE: waits for `i_start`.
  - ACCUM: consumes results.
  - PUSH: writes the record into the FIFO.
- IDLE, `i_start` with cnt>0:
  - `rem`←cnt, `idx`←0, `t_min`←0x7fffffff, `hit`←0.
  - Go to ACCUM.
- IDLE, `i_start` with cnt=0: go straight to PUSH with a no-hit record.
- ACCUM, each `i_valid`:
  - If `i_result` and `i_t` < `t_min` (signed, strict), then `t_min`←`i_t`, `idx_min`←`idx`, `hit`←1.
  - `idx`++, `rem`--.
  - When `rem` reaches 0 on this beat, go to PUSH.
- Ties on `t`: the earlier (lower) index wins.
- PUSH:
  - If the FIFO is not full, write {hit, t_min, idx_min} and go to IDLE.
  - Otherwise stay in PUSH; `o_busy` stays 1.
  - No record is ever dropped.
- `i_start` while `o_busy`=1 is ignored, with no error.
- `i_valid` in IDLE or PUSH: the result is discarded and `o_err`←1. `o_err` is cleared only by reset.
- FIFO:
  - Show-ahead; head is popped on `o_valid` && `i_ready`.
  - A push and a pop in the same cycle are both allowed when the FIFO is full.
- When `o_valid`=0, `o_hit`, `o_t` and `o_tri_idx` read 0.

## Timing
- Reset values:
  - Outputs: `o_busy`=0, `o_valid`=0, `o_hit`=0, `o_t`=0, `o_tri_idx`=0, `o_err`=0.
  - State IDLE, FIFO empty.
- `i_start` at cycle S: `o_busy`=1 from S+1. Results are accepted from S+1; an `i_valid` in cycle S counts as an error.
- Last result at cycle N:
  - PUSH at N+1.
  - With the FIFO not full, the record is written at the end of N+1. `o_valid` and data are visible at N+2; `o_busy`=0 at N+2.
- Next `i_start` is accepted from cycle N+2.
- cnt=0 at cycle S: PUSH at S+1, record visible at S+2.
- Reset mid-batch: all state is discarded, including FIFO contents.
- Index wrap: `idx` is IDX_W bits and wraps modulo 2^IDX_W; cnt ≤ 2^IDX_W−1 by construction.

## Configuration
- `CLOSEST_HIT_STATS_EN` defined:
  - Adds output `o_hit_cnt` (IDX_W): the number of `i_result`=1 beats in the batch.
  - The count is stored alongside each FIFO record and driven with the head; it reads 0 when `o_valid`=0.
- Undefined: no port, no counter, no extra FIFO width.

## Structure
- Shared package `rt_pkg` holds:
  - `typedef logic signed [31:0] fip`.
  - Constants `FIP_ONE`, `FIP_MAX` (0x7fffffff) and `FIP_MIN`.
  - `hit_rec_t` packed struct {hit, t, tri_idx[, hit_cnt]}.
  - State enum `chc_state_e`.
- Sub-module `hit_rec_fifo`: parameterised depth, synchronous show-ahead FIFO of `hit_rec_t`, with full/empty outputs.

## Test plan
- Start cnt=3; results (hit, 0x00020000), (hit, 0x00010000), (miss, 0) → one record: hit=1, t=0x00010000, idx=1.
- Start cnt=4, all misses → hit=0, t=0x7fffffff, idx=0; `o_valid` exactly 2 cycles after the last beat.
- Start cnt=0 → record hit=0 visible 2 cycles after start; `o_busy` high for exactly 1 cycle.
- Tie: two hits with t=0x00008000 at idx 0 and 2 → idx=0; a negative t=0xffff0000 hit beats any positive t.
- Hold `i_ready`=0 across 5 batches with FIFO_DEPTH=4 → 5th batch stalls in PUSH with `o_busy`=1; releasing `i_ready` drains all 5 records in order.
- `i_valid` in IDLE → `o_err`=1 and it stays set; reset asserted mid-ACCUM → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared ray-tracing types: fixed-point t, hit record, collector states
// Optional macro CLOSEST_HIT_STATS_EN adds a per-record hit count field.
package rt_pkg;

  typedef logic signed [31:0] fip;

  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MAX = 32'sh7fff_ffff;
  localparam fip FIP_MIN = 32'sh8000_0000;

  // Record index fields are fixed at this width; narrower IDX_W values are zero-extended.
  localparam int REC_IDX_W = 32;

  typedef struct packed {
    logic                 hit;
    fip                   t;
    logic [REC_IDX_W-1:0] tri_idx;
`ifdef CLOSEST_HIT_STATS_EN
    logic [REC_IDX_W-1:0] hit_cnt;
`endif
  } hit_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PUSH  = 2'd2
  } chc_state_e;

endpackage

// File: rtl/hit_rec_fifo.sv
// rtl/hit_rec_fifo.sv - show-ahead synchronous FIFO of hit records
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module hit_rec_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  hit_rec_t wdata,
  input  logic     pop,
  output hit_rec_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  hit_rec_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/closest_hit_collector.sv
// rtl/closest_hit_collector.sv - per-batch nearest-hit tracker feeding a record FIFO
// Optional macro CLOSEST_HIT_STATS_EN adds o_hit_cnt (hit beats per batch).
module closest_hit_collector
  import rt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [IDX_W-1:0] i_tri_cnt,
  output logic             o_busy,
  input  logic             i_valid,
  input  logic             i_result,
  input  logic [31:0]      i_t,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_hit,
  output logic [31:0]      o_t,
  output logic [IDX_W-1:0] o_tri_idx,
`ifdef CLOSEST_HIT_STATS_EN
  output logic [IDX_W-1:0] o_hit_cnt,
`endif
  output logic             o_err
);

  chc_state_e       state, state_nxt;
  logic [IDX_W-1:0] rem;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_min;
  fip               t_min;
  fip               t_in;
  logic             hit;
  logic             err;
`ifdef CLOSEST_HIT_STATS_EN
  logic [IDX_W-1:0] hit_cnt;
`endif

  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push_done;
  hit_rec_t wrec;
  hit_rec_t hrec;

  assign t_in     = fip'(i_t);
  assign fifo_pop = !fifo_empty && i_ready;
  // Full is not a stall when the consumer frees a slot this same cycle.
  assign push_done = (state == ST_PUSH) && (!fifo_full || fifo_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (i_tri_cnt == '0) ? ST_PUSH : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (i_valid && rem == IDX_W'(1)) state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        if (push_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rem     <= '0;
      idx     <= '0;
      idx_min <= '0;
      t_min   <= FIP_MAX;
      hit     <= 1'b0;
      err     <= 1'b0;
`ifdef CLOSEST_HIT_STATS_EN
      hit_cnt <= '0;
`endif
    end else begin
      if (state == ST_IDLE && i_start) begin
        rem     <= i_tri_cnt;
        idx     <= '0;
        idx_min <= '0;
        t_min   <= FIP_MAX;
        hit     <= 1'b0;
`ifdef CLOSEST_HIT_STATS_EN
        hit_cnt <= '0;
`endif
      end
      if (state == ST_ACCUM && i_valid) begin
        // Strict compare keeps the earlier index on ties.
        if (i_result && (t_in < t_min)) begin
          t_min   <= t_in;
          idx_min <= idx;
          hit     <= 1'b1;
        end
        idx <= idx + IDX_W'(1);
        rem <= rem - IDX_W'(1);
`ifdef CLOSEST_HIT_STATS_EN
        if (i_result) hit_cnt <= hit_cnt + IDX_W'(1);
`endif
      end
      if (i_valid && state != ST_ACCUM) err <= 1'b1;
    end
  end

  always_comb begin
    wrec         = '0;
    wrec.hit     = hit;
    wrec.t       = t_min;
    wrec.tri_idx = REC_IDX_W'(idx_min);
`ifdef CLOSEST_HIT_STATS_EN
    wrec.hit_cnt = REC_IDX_W'(hit_cnt);
`endif
  end

  hit_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .push  (fifo_push),
    .wdata (wrec),
    .pop   (fifo_pop),
    .rdata (hrec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_busy  = (state != ST_IDLE);
  assign o_valid = !fifo_empty;
  assign o_err   = err;

  always_comb begin
    o_hit     = 1'b0;
    o_t       = '0;
    o_tri_idx = '0;
`ifdef CLOSEST_HIT_STATS_EN
    o_hit_cnt = '0;
`endif
    if (!fifo_empty) begin
      o_hit     = hrec.hit;
      o_t       = hrec.t;
      o_tri_idx = hrec.tri_idx[IDX_W-1:0];
`ifdef CLOSEST_HIT_STATS_EN
      o_hit_cnt = hrec.hit_cnt[IDX_W-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_closest_hit_collector.sv
// tb/tb_closest_hit_collector.sv - directed self-checking bench for closest_hit_collector
module tb_closest_hit_collector;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [31:0] i_tri_cnt;
  logic        o_busy;
  logic        i_valid;
  logic        i_result;
  logic [31:0] i_t;
  logic        o_valid;
  logic        i_ready;
  logic        o_hit;
  logic [31:0] o_t;
  logic [31:0] o_tri_idx;
  logic        o_err;
`ifdef CLOSEST_HIT_STATS_EN
  logic [31:0] o_hit_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic        bh [16];
  logic [31:0] bt [16];

  closest_hit_collector #(.FIFO_DEPTH(4), .IDX_W(32)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_start   (i_start),
    .i_tri_cnt (i_tri_cnt),
    .o_busy    (o_busy),
    .i_valid   (i_valid),
    .i_result  (i_result),
    .i_t       (i_t),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_hit     (o_hit),
    .o_t       (o_t),
    .o_tri_idx (o_tri_idx),
`ifdef CLOSEST_HIT_STATS_EN
    .o_hit_cnt (o_hit_cnt),
`endif
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Returns in cycle N+1 (one cycle after the last beat).
  task automatic run_batch(input int cnt, input int nbeats);
    i_start   = 1'b1;
    i_tri_cnt = cnt;
    tick();
    i_start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      i_valid  = 1'b1;
      i_result = bh[b];
      i_t      = bt[b];
      tick();
    end
    i_valid  = 1'b0;
    i_result = 1'b0;
    i_t      = '0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_tri_cnt = '0;
    i_valid = 1'b0; i_result = 1'b0; i_t = '0; i_ready = 1'b1;
    tick(); tick();
    i_rstn = 1'b1;
    tick();
    tests++;
    if ({o_busy, o_valid, o_hit, o_err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: busy/valid/hit/err=%b required 0000", {o_busy, o_valid, o_hit, o_err});
    end
    tests++;
    if (o_t !== 32'h0 || o_tri_idx !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: t=%h idx=%h required 0/0", o_t, o_tri_idx);
    end
  endtask

  task automatic test_basic();
    bh[0] = 1'b1; bt[0] = 32'h0002_0000;
    bh[1] = 1'b1; bt[1] = 32'h0001_0000;
    bh[2] = 1'b0; bt[2] = 32'h0;
    i_start = 1'b1; i_tri_cnt = 3;
    tick();
    i_start = 1'b0;
    tests++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: busy=%b required 1", o_busy);
    end
    for (int b = 0; b < 3; b++) begin
      i_valid = 1'b1; i_result = bh[b]; i_t = bt[b];
      tick();
    end
    i_valid = 1'b0; i_result = 1'b0; i_t = '0;
    tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_n1: valid=%b busy=%b required 0/1", o_valid, o_busy);
    end
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_busy !== 1'b0 || o_hit !== 1'b1 ||
        o_t !== 32'h0001_0000 || o_tri_idx !== 32'd1) begin
      fails++;
      $display("FAIL basic_rec: valid=%b busy=%b hit=%b t=%h idx=%0d required 1/0/1/00010000/1",
               o_valid, o_busy, o_hit, o_t, o_tri_idx);
    end
`ifdef CLOSEST_HIT_STATS_EN
    tests++;
    if (o_hit_cnt !== 32'd2) begin
      fails++;
      $display("FAIL basic_hit_cnt: got %0d required 2", o_hit_cnt);
    end
`endif
    tick();
    tests++;
    if (o_valid !== 1'b0 || o_hit !== 1'b0 || o_t !== 32'h0 || o_tri_idx !== 32'h0) begin
      fails++;
      $display("FAIL basic_popped: valid=%b hit=%b t=%h idx=%h required all 0", o_valid, o_hit, o_t, o_tri_idx);
    end
  endtask

  task automatic test_all_miss();
    for (int b = 0; b < 4; b++) begin bh[b] = 1'b0; bt[b] = 32'h0000_1000 * (b + 1); end
    run_batch(4, 4);
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL miss_early: valid=%b required 0", o_valid);
    end
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_hit !== 1'b0 || o_t !== 32'h7fff_ffff || o_tri_idx !== 32'd0) begin
      fails++;
      $display("FAIL miss_rec: valid=%b hit=%b t=%h idx=%0d required 1/0/7fffffff/0", o_valid, o_hit, o_t, o_tri_idx);
    end
    tick();
  endtask

  task automatic test_zero_cnt();
    i_start = 1'b1; i_tri_cnt = 0;
    tick();
    i_start = 1'b0;
    tests++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_s1: busy=%b valid=%b required 1/0", o_busy, o_valid);
    end
    tick();
    tests++;
    if (o_busy !== 1'b0 || o_valid !== 1'b1 || o_hit !== 1'b0 || o_t !== 32'h7fff_ffff) begin
      fails++;
      $display("FAIL zero_s2: busy=%b valid=%b hit=%b t=%h required 0/1/0/7fffffff", o_busy, o_valid, o_hit, o_t);
    end
    tick();
  endtask

  task automatic test_tie_and_negative();
    bh[0] = 1'b1; bt[0] = 32'h0000_8000;
    bh[1] = 1'b0; bt[1] = 32'h0000_0100;
    bh[2] = 1'b1; bt[2] = 32'h0000_8000;
    run_batch(3, 3);
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_hit !== 1'b1 || o_t !== 32'h0000_8000 || o_tri_idx !== 32'd0) begin
      fails++;
      $display("FAIL tie_rec: valid=%b hit=%b t=%h idx=%0d required 1/1/00008000/0", o_valid, o_hit, o_t, o_tri_idx);
    end
    tick();
    bh[0] = 1'b1; bt[0] = 32'h0005_0000;
    bh[1] = 1'b1; bt[1] = 32'hffff_0000;
    bh[2] = 1'b1; bt[2] = 32'h0001_0000;
    run_batch(3, 3);
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_hit !== 1'b1 || o_t !== 32'hffff_0000 || o_tri_idx !== 32'd1) begin
      fails++;
      $display("FAIL neg_rec: valid=%b hit=%b t=%h idx=%0d required 1/1/ffff0000/1", o_valid, o_hit, o_t, o_tri_idx);
    end
`ifdef CLOSEST_HIT_STATS_EN
    tests++;
    if (o_hit_cnt !== 32'd3) begin
      fails++;
      $display("FAIL neg_hit_cnt: got %0d required 3", o_hit_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bh[0] = 1'b1; bt[0] = (k + 1) << 16;
      run_batch(1, 1);
      tick();
    end
    tick(); tick();
    tests++;
    if (o_busy !== 1'b1 || o_valid !== 1'b1 || o_t !== 32'h0001_0000) begin
      fails++;
      $display("FAIL stall: busy=%b valid=%b head_t=%h required 1/1/00010000", o_busy, o_valid, o_t);
    end
    i_start = 1'b1; i_tri_cnt = 0;
    tick();
    i_start = 1'b0;
    tests++;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      fails++;
      $display("FAIL ignored_start: busy=%b err=%b required 1/0", o_busy, o_err);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (o_valid !== 1'b1 || o_t !== ((k + 1) << 16)) begin
        fails++;
        $display("FAIL drain_%0d: valid=%b t=%h required 1/%h", k, o_valid, o_t, (k + 1) << 16);
      end
      tick();
    end
    tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_end: valid=%b busy=%b required 0/0", o_valid, o_busy);
    end
  endtask

  task automatic test_err();
    tests++;
    if (o_err !== 1'b0) begin
      fails++;
      $display("FAIL err_pre: err=%b required 0", o_err);
    end
    i_valid = 1'b1; i_result = 1'b1; i_t = 32'h0000_0001;
    tick();
    i_valid = 1'b0; i_result = 1'b0; i_t = '0;
    tests++;
    if (o_err !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_set: err=%b valid=%b required 1/0", o_err, o_valid);
    end
    bh[0] = 1'b0; bt[0] = 32'h0;
    run_batch(1, 1);
    tick(); tick(); tick();
    tests++;
    if (o_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: err=%b required 1", o_err);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    bh[0] = 1'b1; bt[0] = 32'h0000_4000;
    run_batch(1, 1);
    tick();
    bh[0] = 1'b1; bt[0] = 32'h0000_2000;
    bh[1] = 1'b0; bt[1] = 32'h0;
    run_batch(5, 2);
    tests++;
    if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre: busy=%b valid=%b required 1/1", o_busy, o_valid);
    end
    i_rstn = 1'b0;
    tick();
    tests++;
    if ({o_busy, o_valid, o_hit, o_err} !== 4'b0000 || o_t !== 32'h0 || o_tri_idx !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: busy/valid/hit/err=%b t=%h idx=%h required 0000/0/0",
               {o_busy, o_valid, o_hit, o_err}, o_t, o_tri_idx);
    end
    i_rstn = 1'b1;
    i_ready = 1'b1;
    tick(); tick();
    tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_after: valid=%b busy=%b required 0/0", o_valid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_miss();
    test_zero_cnt();
    test_tie_and_negative();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
